cic_decimator: RTL and testbench
================================

// Module: cic_decimator
// PURPOSE
//  First decimation stage of the ADC chain: N-th order CIC decimator fed by the modulator word.
//  Decimates by a runtime-selectable R = 2^k (k = 4..7) and delivers a 35-bit signed stream with
//  a single-cycle valid strobe. The output feeds the half-band chain, one clk_vld_in per sample.
// PARAMETERS
//  N_ORDER    5   number of integrator and comb stages
//  IN_W       4   modulator word width, signed two's complement
//  RMAX_LOG2  7   log2 of the largest decimation ratio (R = 128)
//  OUT_W      35  output width
//  ACC_W      IN_W+N_ORDER*RMAX_LOG2 (=39)  internal width, derived; do not override
// PORTS
//  clk          in   1      system clock
//  rstn         in   1      asynchronous active-low reset
//  clk_vld_in   in   1      input sample strobe; dat_in is valid in this cycle
//  dat_in       in   IN_W   signed modulator sample
//  rate_sel     in   2      0:R=16  1:R=32  2:R=64  3:R=128 (k = rate_sel+4)
//  clk_vld_out  out  1      one-cycle output strobe
//  dat_out      out  OUT_W  signed decimated sample; holds its value between strobes
// BEHAVIOUR
//  - Reset (async, rstn=0): integrators, comb delays, decimation counter, settle counter and
//    rate_q clear to 0. Outputs clk_vld_out=0 and dat_out=0.
//  - Integrators: pipelined chain. int[0] += dat_in (sign-extended), int[i] += int[i-1].
//    Each stage updates only when clk_vld_in=1. All sums are ACC_W bits and wrap modulo 2^ACC_W.
//    Wrap is intended; there is no saturation.
//  - Decimation counter: counts clk_vld_in pulses from 0 to R-1. On the pulse where cnt==R-1
//    it returns to 0 and sets dec_stb, a register, for 1 cycle.
//  - Comb: in the dec_stb cycle, c[0]=int[N-1] and c[i]=c[i-1]-dly[i]. Then dly[i]<=c[i-1]
//    (differential delay M=1). The comb result c[N] is ACC_W bits with wrap arithmetic.
//  - Output: dat_out<=(c[N] after scaling)>>>(ACC_W-OUT_W). clk_vld_out asserts in the cycle
//    after dec_stb. Latency is 2 clk from the R-th input strobe to clk_vld_out.
//    Output rate is exactly 1 per R clk_vld_in pulses, regardless of gaps in clk_vld_in.
//  - Settling: the first N_ORDER comb results after reset or a flush update the comb delays.
//    For these results clk_vld_out stays 0 and dat_out is not written.
//  - Rate change: rate_sel is compared every cycle with rate_q. On a mismatch, the block flushes
//    in that cycle: rate_q<=rate_sel; integrators, delays, counter and settle count clear to 0;
//    any pending dec_stb is dropped. dat_out keeps its last value.
//    If clk_vld_in arrives in the flush cycle, that input is discarded.
//  - Boundaries: full-scale input -8 at R=128 gives -2^38, which fits ACC_W exactly.
//    clk_vld_in held high continuously is legal. A rate change in the dec_stb cycle flushes,
//    and that output is not emitted.
// CONFIGURATION
//  CIC_GAIN_NORM_EN defined: before truncation, c[N] is shifted left by
//    N_ORDER*(RMAX_LOG2-k), ACC_W bits. DC gain is then 2^(N*RMAX_LOG2) at every rate.
//  CIC_GAIN_NORM_EN undefined: no shift. DC gain is R^N, so the output is smaller at lower R.
// STRUCTURE
//  - Package cic_pkg holds:
//    - CIC_N, CIC_IN_W, CIC_RMAX_LOG2, CIC_ACC_W and CIC_OUT_W;
//    - function rate_log2(rate_sel) and function norm_shift(rate_sel);
//    - a rate_sel enum: R16, R32, R64, R128.
//  - Sub-module cic_comb_stage (ACC_W): one registered delay with enable and clear.
//    It performs the subtraction and is instantiated N_ORDER times.
//  - Integrators, counter, settle logic and output register live in the top level.
// TESTING
//  1. rate_sel=3, dat_in=+1 constant, clk_vld_in every cycle:
//     -> after the 5 suppressed outputs, every 128 clk dat_out=2^31 (2147483648).
//  2. rate_sel=0, dat_in=+1, with norm enabled -> dat_out=2147483648.
//     With CIC_GAIN_NORM_EN undefined -> dat_out=65536.
//  3. rate_sel=3, dat_in=-8 constant -> settled dat_out=-2^34 (-17179869184), with no wrap error.
//  4. clk_vld_in=1 every 3rd clk, R=32 -> clk_vld_out exactly every 96 clk.
//     Each strobe is 1 cycle wide and 2 clk after the 32nd input strobe.
//  5. Mid-stream, switch rate_sel 3->1 -> no clk_vld_out for the next 5*32 inputs.
//     The first new strobe comes on the 192nd accepted input after the flush cycle.
//  6. Drop rstn for 1 cycle mid-output -> clk_vld_out=0 and dat_out=0 at once.
//     The block then resumes with the 5-output settle.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants, rate-select encoding and rate helpers for the CIC decimator.
package cic_pkg;

    localparam int CIC_N         = 5;
    localparam int CIC_IN_W      = 4;
    localparam int CIC_RMAX_LOG2 = 7;
    localparam int CIC_ACC_W     = CIC_IN_W + CIC_N * CIC_RMAX_LOG2;
    localparam int CIC_OUT_W     = 35;

    typedef enum logic [1:0] {
        R16  = 2'd0,
        R32  = 2'd1,
        R64  = 2'd2,
        R128 = 2'd3
    } rate_e;

    // k = rate_sel + 4, so prefixing a 1 gives k directly.
    function automatic logic [2:0] rate_log2(input logic [1:0] rate_sel);
        return {1'b1, rate_sel};
    endfunction

    function automatic logic [5:0] norm_shift(input logic [1:0] rate_sel);
        return 6'(CIC_N * (CIC_RMAX_LOG2 - int'(rate_log2(rate_sel))));
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: registered differential delay (M=1) with enable/clear and the subtraction.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int ACC_W = CIC_ACC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] dout
);

    logic [ACC_W-1:0] dly_q;
    logic [ACC_W-1:0] dly_d;

    always_comb begin
        dly_d = dly_q;
        if (clr) begin
            dly_d = '0;
        end else if (en) begin
            dly_d = din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign dout = din - dly_q;

endmodule

// File: rtl/cic_decimator.sv
// N-th order CIC decimator, R = 2^(rate_sel+4), 35-bit output with one-cycle valid strobe.
// Define CIC_GAIN_NORM_EN to equalise the DC gain to 2^(N*RMAX_LOG2) at every rate.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int N_ORDER   = CIC_N,
    parameter int IN_W      = CIC_IN_W,
    parameter int RMAX_LOG2 = CIC_RMAX_LOG2,
    parameter int OUT_W     = CIC_OUT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clk_vld_in,
    input  logic [IN_W-1:0]  dat_in,
    input  logic [1:0]       rate_sel,
    output logic             clk_vld_out,
    output logic [OUT_W-1:0] dat_out
);

    localparam int ACC_W = IN_W + N_ORDER * RMAX_LOG2;
    localparam int SET_W = $clog2(N_ORDER + 1);

    logic [ACC_W-1:0]     integ_q [N_ORDER];
    logic [ACC_W-1:0]     integ_d [N_ORDER];
    logic [ACC_W-1:0]     comb_c  [N_ORDER+1];
    logic [RMAX_LOG2-1:0] cnt_q, cnt_d, term_cnt;
    logic [SET_W-1:0]     settle_q, settle_d;
    rate_e                rate_q, rate_d;
    logic                 dec_stb_q, dec_stb_d;
    logic                 vld_out_q, vld_out_d;
    logic [OUT_W-1:0]     dat_out_q, dat_out_d;
    logic [ACC_W-1:0]     scaled;
    logic                 flush;
    logic                 comb_en;

    // A rate mismatch restarts the whole filter; the incoming sample and any pending result are lost.
    assign flush    = (rate_sel != rate_q);
    assign comb_en  = dec_stb_q & ~flush;
    assign term_cnt = RMAX_LOG2'((1 << rate_log2(rate_q)) - 1);

    always_comb begin
        for (int i = 0; i < N_ORDER; i++) begin
            integ_d[i] = integ_q[i];
        end
        if (flush) begin
            for (int i = 0; i < N_ORDER; i++) begin
                integ_d[i] = '0;
            end
        end else if (clk_vld_in) begin
            integ_d[0] = integ_q[0] + {{(ACC_W-IN_W){dat_in[IN_W-1]}}, dat_in};
            for (int i = 1; i < N_ORDER; i++) begin
                integ_d[i] = integ_q[i] + integ_q[i-1];
            end
        end
    end

    assign comb_c[0] = integ_q[N_ORDER-1];

    for (genvar g = 0; g < N_ORDER; g++) begin : g_comb
        cic_comb_stage #(
            .ACC_W (ACC_W)
        ) u_stage (
            .clk  (clk),
            .rstn (rstn),
            .en   (comb_en),
            .clr  (flush),
            .din  (comb_c[g]),
            .dout (comb_c[g+1])
        );
    end

`ifdef CIC_GAIN_NORM_EN
    assign scaled = comb_c[N_ORDER] << norm_shift(rate_q);
`else
    assign scaled = comb_c[N_ORDER];
`endif

    always_comb begin
        rate_d    = rate_q;
        cnt_d     = cnt_q;
        dec_stb_d = 1'b0;
        settle_d  = settle_q;
        vld_out_d = 1'b0;
        dat_out_d = dat_out_q;
        if (flush) begin
            rate_d   = rate_e'(rate_sel);
            cnt_d    = '0;
            settle_d = '0;
        end else begin
            if (clk_vld_in) begin
                if (cnt_q == term_cnt) begin
                    cnt_d     = '0;
                    dec_stb_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + RMAX_LOG2'(1);
                end
            end
            // The first N_ORDER comb results only prime the delays.
            if (dec_stb_q) begin
                if (settle_q < SET_W'(N_ORDER)) begin
                    settle_d = settle_q + SET_W'(1);
                end else begin
                    vld_out_d = 1'b1;
                    dat_out_d = OUT_W'($signed(scaled) >>> (ACC_W - OUT_W));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_ORDER; i++) begin
                integ_q[i] <= '0;
            end
            cnt_q     <= '0;
            settle_q  <= '0;
            rate_q    <= R16;
            dec_stb_q <= 1'b0;
            vld_out_q <= 1'b0;
            dat_out_q <= '0;
        end else begin
            for (int i = 0; i < N_ORDER; i++) begin
                integ_q[i] <= integ_d[i];
            end
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            rate_q    <= rate_d;
            dec_stb_q <= dec_stb_d;
            vld_out_q <= vld_out_d;
            dat_out_q <= dat_out_d;
        end
    end

    assign clk_vld_out = vld_out_q;
    assign dat_out     = dat_out_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: DC vectors per rate plus rate-change and reset sequences.
`timescale 1ns/1ps
module tb_cic_decimator;

    typedef struct {
        logic [1:0]        rate;
        logic signed [3:0] din;
        int                stride;
        longint            expv;
    } vec_t;

    localparam longint E_P1_R128 = 64'sd2147483648;
    localparam longint E_N8_R128 = -64'sd17179869184;
`ifdef CIC_GAIN_NORM_EN
    localparam longint E_P1_R16  = 64'sd2147483648;
    localparam longint E_P1_R32  = 64'sd2147483648;
    localparam longint E_N3_R64  = -64'sd6442450944;
    localparam longint E_P7_R16  = 64'sd15032385536;
`else
    localparam longint E_P1_R16  = 64'sd65536;
    localparam longint E_P1_R32  = 64'sd2097152;
    localparam longint E_N3_R64  = -64'sd201326592;
    localparam longint E_P7_R16  = 64'sd458752;
`endif

    logic        clk        = 1'b0;
    logic        rstn       = 1'b1;
    logic        clk_vld_in = 1'b0;
    logic [3:0]  dat_in     = 4'd0;
    logic [1:0]  rate_sel   = 2'd0;
    logic        clk_vld_out;
    logic [34:0] dat_out;

    int          checks  = 0;
    int          errors  = 0;
    int          strobes = 0;
    int          n       = 0;
    int          r_cur   = 16;
    logic [1:0]  dut_rate = 2'd0;
    logic [1:0]  pipe    = 2'b00;
    longint      exp_val = 0;
    vec_t        vecs [6];

    cic_decimator dut (
        .clk         (clk),
        .rstn        (rstn),
        .clk_vld_in  (clk_vld_in),
        .dat_in      (dat_in),
        .rate_sel    (rate_sel),
        .clk_vld_out (clk_vld_out),
        .dat_out     (dat_out)
    );

    always #5 clk = ~clk;

    // One clock: check outputs against the model, then drive the next input and rate.
    task automatic step(input logic vin, input logic [1:0] rsel);
        logic exp_now;
        @(negedge clk);
        exp_now = pipe[1];
        if (exp_now || clk_vld_out) begin
            checks++;
            if (exp_now !== clk_vld_out) begin
                errors++;
                $display("FAIL strobe_timing t=%0t n=%0d: clk_vld_out=%0b required %0b",
                         $time, n, clk_vld_out, exp_now);
            end else begin
                checks++;
                if (longint'($signed(dat_out)) != exp_val) begin
                    errors++;
                    $display("FAIL strobe_value t=%0t n=%0d: dat_out=%0d required %0d",
                             $time, n, longint'($signed(dat_out)), exp_val);
                end
            end
        end
        if (clk_vld_out) strobes++;
        pipe[1] = pipe[0];
        pipe[0] = 1'b0;
        if (rsel != dut_rate) begin
            pipe     = 2'b00;
            n        = 0;
            dut_rate = rsel;
            r_cur    = 16 << rsel;
        end else if (vin) begin
            n++;
            pipe[0] = ((n % r_cur) == 0) && (n >= 6 * r_cur);
        end
        rate_sel   = rsel;
        clk_vld_in = vin;
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        clk_vld_in = 1'b0;
        #1;
        checks++;
        if (clk_vld_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: clk_vld_out=%0b required 0", clk_vld_out);
        end
        checks++;
        if (dat_out !== 35'd0) begin
            errors++;
            $display("FAIL reset_dat: dat_out=%0d required 0", longint'($signed(dat_out)));
        end
        pipe     = 2'b00;
        n        = 0;
        dut_rate = 2'd0;
        r_cur    = 16;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_strobes(input int required, input int tag);
        checks++;
        if (strobes != required) begin
            errors++;
            $display("FAIL strobe_count[%0d]: strobes=%0d required %0d", tag, strobes, required);
        end
    endtask

    initial begin
        bit found;

        vecs[0] = '{rate: 2'd3, din:  4'sd1, stride: 1, expv: E_P1_R128};
        vecs[1] = '{rate: 2'd0, din:  4'sd1, stride: 1, expv: E_P1_R16};
        vecs[2] = '{rate: 2'd3, din: -4'sd8, stride: 1, expv: E_N8_R128};
        vecs[3] = '{rate: 2'd1, din:  4'sd1, stride: 3, expv: E_P1_R32};
        vecs[4] = '{rate: 2'd2, din: -4'sd3, stride: 2, expv: E_N3_R64};
        vecs[5] = '{rate: 2'd0, din:  4'sd7, stride: 1, expv: E_P7_R16};

        #2;
        for (int v = 0; v < 6; v++) begin
            do_reset();
            dat_in  = vecs[v].din;
            exp_val = vecs[v].expv;
            strobes = 0;
            step(1'b0, vecs[v].rate);
            step(1'b0, vecs[v].rate);
            for (int c = 0; c < 8 * r_cur * vecs[v].stride + 4; c++) begin
                step(((c % vecs[v].stride) == 0) && (c < 8 * r_cur * vecs[v].stride), vecs[v].rate);
            end
            check_strobes(3, v);
        end

        // Rate change 128 -> 32 landing exactly in the dec_stb cycle of the 7th output.
        do_reset();
        dat_in  = 4'sd1;
        exp_val = E_P1_R128;
        strobes = 0;
        step(1'b0, 2'd3);
        step(1'b0, 2'd3);
        for (int c = 0; c < 7 * 128; c++) step(1'b1, 2'd3);
        step(1'b1, 2'd1);
        check_strobes(1, 10);
        step(1'b0, 2'd1);
        checks++;
        if (longint'($signed(dat_out)) != E_P1_R128) begin
            errors++;
            $display("FAIL flush_hold: dat_out=%0d required %0d", longint'($signed(dat_out)), E_P1_R128);
        end
        exp_val = E_P1_R32;
        strobes = 0;
        for (int c = 0; c < 7 * 32 + 4; c++) step(c < 7 * 32, 2'd1);
        check_strobes(2, 11);

        // Reset pulse while clk_vld_out is high, then a full settle again.
        do_reset();
        dat_in  = 4'sd1;
        exp_val = E_P1_R16;
        strobes = 0;
        found   = 1'b0;
        step(1'b0, 2'd0);
        step(1'b0, 2'd0);
        for (int c = 0; c < 200 && !found; c++) begin
            step(1'b1, 2'd0);
            found = clk_vld_out;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL first_strobe_timeout: clk_vld_out=0 required 1 within 200 clk");
        end
        do_reset();
        strobes = 0;
        step(1'b0, 2'd0);
        step(1'b0, 2'd0);
        for (int c = 0; c < 8 * 16 + 4; c++) step(c < 8 * 16, 2'd0);
        check_strobes(3, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
